imem_uart_loader: RTL and testbench

Loads programs into the single-cycle CPU's instruction memory over a UART link. It is the writer side of the instruction-memory port that the CPU only reads. While loading, it holds the CPU in reset. Each received 32-bit word is written as a one-cycle write strobe. When loading finishes, it reports done or an error code for the LED and seven-segment display path.

---
 rtl/imem_uart_loader_pkg.sv | 31 +++
 rtl/imem_uart_loader_rx.sv | 92 +++++++++
 rtl/imem_uart_loader.sv | 140 ++++++++++++++
 tb/tb_imem_uart_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package imem_uart_loader_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StCntH,
      StCntL,
      StData,
      StCsum,
      StDone,
      StErr
   } state_e;

   // Byte receiver states
   typedef enum logic [1:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop
   } rx_state_e;

   localparam logic [7:0] SyncByte = 8'hA5;

   localparam logic [1:0] ErrNone  = 2'd0;
   localparam logic [1:0] ErrFrame = 2'd1;
   localparam logic [1:0] ErrCsum  = 2'd2;
   localparam logic [1:0] ErrOvf   = 2'd3;

endpackage

// File: rtl/imem_uart_loader_rx.sv
// 8N1 UART byte receiver with start-bit glitch rejection and stop-bit check.
module uart_rx_byte
   import imem_uart_loader_pkg::*;
#(
   parameter int unsigned DIV = 10
) (
   input  logic       clk,
   input  logic       rst_out,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int unsigned CntW = $clog2(DIV);

   rx_state_e       state_q;
   logic [1:0]      sync_q;
   logic            line_prev_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;

   // Synchronize the line, detect start edges and sample bits at mid-bit points.
   always_ff @(posedge clk or posedge rst_out) begin
      if (rst_out) begin
         state_q     <= RxIdle;
         sync_q      <= 2'b11;  // idle-high so reset release is not a start edge
         line_prev_q <= 1'b1;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_byte     <= '0;
         rx_valid    <= 1'b0;
         rx_ferr     <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], rxd};
         line_prev_q <= sync_q[1];
         rx_valid    <= 1'b0;
         rx_ferr     <= 1'b0;
         case (state_q)
            RxIdle: begin
               if (line_prev_q && !sync_q[1]) begin
                  state_q <= RxStart;
                  cnt_q   <= CntW'(DIV / 2 - 1);
               end
            end
            RxStart: begin
               if (cnt_q == '0) begin
                  if (sync_q[1]) begin
                     state_q <= RxIdle;  // line back high: glitch
                  end else begin
                     state_q   <= RxData;
                     cnt_q     <= CntW'(DIV - 1);
                     bit_idx_q <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RxData: begin
               if (cnt_q == '0) begin
                  shift_q <= {sync_q[1], shift_q[7:1]};
                  cnt_q   <= CntW'(DIV - 1);
                  if (bit_idx_q == 3'd7) begin
                     state_q <= RxStop;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RxStop: begin
               if (cnt_q == '0) begin
                  if (sync_q[1]) begin
                     rx_valid <= 1'b1;
                     rx_byte  <= shift_q;
                  end else begin
                     rx_ferr <= 1'b1;
                  end
                  state_q <= RxIdle;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= RxIdle;
         endcase
      end
   end

endmodule

// File: rtl/imem_uart_loader.sv
// Receives a framed program over UART and writes it into instruction memory.
module imem_uart_loader
   import imem_uart_loader_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 115_200,
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DEPTH  = 512
) (
   input  logic              clk,
   input  logic              rst_out,
   input  logic              rxd,
   input  logic              start,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_din,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err,
   output logic [15:0]       word_cnt
);

   localparam int unsigned DIV      = CLK_HZ / BAUD;
   localparam logic [16:0] DepthLim = 17'(DEPTH);

   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        rx_ferr;

   state_e      state_q;
   logic [15:0] n_q;
   logic [7:0]  acc_q;
   logic [23:0] word_q;
   logic [1:0]  byte_idx_q;
   logic [15:0] n_new;

   assign n_new = {n_q[15:8], rx_byte};

   uart_rx_byte #(
      .DIV(DIV)
   ) u_rx (
      .clk     (clk),
      .rst_out (rst_out),
      .rxd     (rxd),
      .rx_byte (rx_byte),
      .rx_valid(rx_valid),
      .rx_ferr (rx_ferr)
   );

   // Frame-parsing FSM with word assembly, address counter and registered outputs.
   always_ff @(posedge clk or posedge rst_out) begin
      if (rst_out) begin
         state_q    <= StIdle;
         n_q        <= '0;
         acc_q      <= '0;
         word_q     <= '0;
         byte_idx_q <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_din   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= ErrNone;
         word_cnt   <= '0;
      end else begin
         imem_we <= 1'b0;
         if (rx_ferr && state_q != StIdle && state_q != StDone && state_q != StErr) begin
            state_q <= StErr;
            err     <= ErrFrame;
            busy    <= 1'b0;
         end else begin
            case (state_q)
               StIdle, StDone, StErr: begin
                  if (start) begin
                     state_q    <= StSync;
                     busy       <= 1'b1;
                     done       <= 1'b0;
                     err        <= ErrNone;
                     word_cnt   <= '0;
                     imem_addr  <= '0;
                     acc_q      <= '0;
                     byte_idx_q <= '0;
                     n_q        <= '0;
                  end
               end
               StSync: begin
                  if (rx_valid && rx_byte == SyncByte) state_q <= StCntH;
               end
               StCntH: begin
                  if (rx_valid) begin
                     n_q[15:8] <= rx_byte;
                     state_q   <= StCntL;
                  end
               end
               StCntL: begin
                  if (rx_valid) begin
                     n_q[7:0] <= rx_byte;
                     if ({1'b0, n_new} > DepthLim) begin
                        state_q <= StErr;
                        err     <= ErrOvf;
                        busy    <= 1'b0;
                     end else if (n_new == 16'd0) begin
                        state_q <= StCsum;
                     end else begin
                        state_q <= StData;
                     end
                  end
               end
               StData: begin
                  if (rx_valid) begin
                     acc_q      <= acc_q ^ rx_byte;
                     word_q     <= {word_q[15:0], rx_byte};
                     byte_idx_q <= byte_idx_q + 1'b1;
                     if (byte_idx_q == 2'd3) begin
                        imem_we   <= 1'b1;
                        imem_din  <= {word_q, rx_byte};
                        imem_addr <= ADDR_W'(word_cnt);
                        word_cnt  <= word_cnt + 16'd1;
                        if (word_cnt + 16'd1 == n_q) state_q <= StCsum;
                     end
                  end
               end
               StCsum: begin
                  if (rx_valid) begin
                     busy <= 1'b0;
                     if (rx_byte == acc_q) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                     end else begin
                        state_q <= StErr;
                        err     <= ErrCsum;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed self-checking bench for imem_uart_loader (DIV = 10).
module tb_imem_uart_loader;

   localparam int DIV = 10;

   logic        clk = 1'b0;
   logic        rst_out;
   logic        rxd;
   logic        start;
   logic        imem_we;
   logic [8:0]  imem_addr;
   logic [31:0] imem_din;
   logic        busy;
   logic        done;
   logic [1:0]  err;
   logic [15:0] word_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   int          wr_total = 0;
   logic [8:0]  wr_addr[16];
   logic [31:0] wr_din[16];
   int          base;

   imem_uart_loader #(
      .CLK_HZ(1_000_000),
      .BAUD  (100_000),
      .ADDR_W(9),
      .DEPTH (512)
   ) dut (
      .clk      (clk),
      .rst_out  (rst_out),
      .rxd      (rxd),
      .start    (start),
      .imem_we  (imem_we),
      .imem_addr(imem_addr),
      .imem_din (imem_din),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   // Log every write strobe seen mid-cycle.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr[wr_total % 16] = imem_addr;
         wr_din[wr_total % 16]  = imem_din;
         wr_total++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      @(negedge clk) rxd = 1'b0;
      repeat (DIV - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk) rxd = b[i];
         repeat (DIV - 1) @(negedge clk);
      end
      @(negedge clk) rxd = stop_bit;
      repeat (DIV - 1) @(negedge clk);
   endtask

   task automatic settle();
      repeat (6) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   initial begin
      rst_out = 1'b1;
      rxd     = 1'b1;
      start   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_wcnt", 32'(word_cnt), 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_din", imem_din, 32'd0);
      rst_out = 1'b0;
      repeat (5) @(negedge clk);

      // Good load of two words
      base = wr_total;
      pulse_start();
      check("good_busy_rise", 32'(busy), 32'd1);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
      send_byte(8'h00);
      settle();
      check("good_nwr", 32'(wr_total - base), 32'd2);
      check("good_addr0", 32'(wr_addr[base % 16]), 32'd0);
      check("good_din0", wr_din[base % 16], 32'h12345678);
      check("good_addr1", 32'(wr_addr[(base + 1) % 16]), 32'd1);
      check("good_din1", wr_din[(base + 1) % 16], 32'h9ABCDEF0);
      check("good_done", 32'(done), 32'd1);
      check("good_err", 32'(err), 32'd0);
      check("good_wcnt", 32'(word_cnt), 32'd2);
      check("good_busy", 32'(busy), 32'd0);

      // Bad checksum: writes still land
      base = wr_total;
      pulse_start();
      check("csum_clear_done", 32'(done), 32'd0);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
      send_byte(8'h01);
      settle();
      check("csum_nwr", 32'(wr_total - base), 32'd2);
      check("csum_err", 32'(err), 32'd2);
      check("csum_done", 32'(done), 32'd0);
      check("csum_busy", 32'(busy), 32'd0);

      // Overflow: N = 513
      base = wr_total;
      pulse_start();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
      settle();
      check("ovf_err", 32'(err), 32'd3);
      check("ovf_busy", 32'(busy), 32'd0);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      settle();
      check("ovf_nwr", 32'(wr_total - base), 32'd0);

      // Framing error inside the first data word
      base = wr_total;
      pulse_start();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h12); send_byte(8'h34, 1'b0);
      @(negedge clk) rxd = 1'b1;
      repeat (20) @(negedge clk);
      check("ferr_err", 32'(err), 32'd1);
      check("ferr_busy", 32'(busy), 32'd0);
      send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A);
      settle();
      check("ferr_nwr", 32'(wr_total - base), 32'd0);
      check("ferr_done", 32'(done), 32'd0);

      // Noise bytes and a short glitch before a one-word frame
      base = wr_total;
      pulse_start();
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      @(negedge clk) rxd = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk) rxd = 1'b1;
      repeat (20) @(negedge clk);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      send_byte(8'h22);
      settle();
      check("noise_nwr", 32'(wr_total - base), 32'd1);
      check("noise_addr", 32'(wr_addr[base % 16]), 32'd0);
      check("noise_din", wr_din[base % 16], 32'hDEADBEEF);
      check("noise_done", 32'(done), 32'd1);
      check("noise_wcnt", 32'(word_cnt), 32'd1);

      // Empty program: N = 0, checksum 00
      pulse_start();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      settle();
      check("empty_done", 32'(done), 32'd1);
      check("empty_wcnt", 32'(word_cnt), 32'd0);

      // Reset in the middle of DATA
      pulse_start();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66);
      @(negedge clk) rst_out = 1'b1;
      @(negedge clk);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_wcnt", 32'(word_cnt), 32'd0);
      check("mrst_addr", 32'(imem_addr), 32'd0);
      check("mrst_din", imem_din, 32'd0);
      check("mrst_we", 32'(imem_we), 32'd0);
      rst_out = 1'b0;
      base = wr_total;
      send_byte(8'h77); send_byte(8'h88);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      settle();
      check("mrst_nwr", 32'(wr_total - base), 32'd0);
      check("mrst_busy_after", 32'(busy), 32'd0);
      check("mrst_done_after", 32'(done), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
